// File: rtl/prog_loader.sv
// Framed byte-stream loader: packs big-endian byte pairs into 16-bit opcodes and writes them to imem from address 0.
// The write strobe comes one cycle after the low byte. rx_ready is held high after reset, so it never stalls the sender.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, W_HI, W_LO, CSUM, DONE, ERR} state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  state_t            state, state_nxt;
  logic              rdy_q;
  logic [7:0]        cnt_hi;
  logic [15:0]       cnt;
  logic [ADDR_W:0]   idx;
  logic [7:0]        hi_byte;
  logic [7:0]        csum;
  logic              acc;
  logic [15:0]       cnt_new;
  logic              cnt_bad;
  logic              last_word;

  assign acc     = rx_valid && rdy_q;
  assign cnt_new = {cnt_hi, rx_data};
  // Count is compared at full width so 2^ADDR_W itself is a legal frame length.
  assign cnt_bad   = (cnt_new == 16'd0) || ({16'd0, cnt_new} > (32'd1 << ADDR_W));
  assign last_word = (32'(idx) + 32'd1) == {16'd0, cnt};

  assign rx_ready = rdy_q;
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        IDLE:    if (rx_data == HDR_BYTE) state_nxt = CNT_HI;
        CNT_HI:  state_nxt = CNT_LO;
        CNT_LO:  state_nxt = cnt_bad ? ERR : W_HI;
        W_HI:    state_nxt = W_LO;
        W_LO:    state_nxt = last_word ? CSUM : W_HI;
        CSUM:    state_nxt = (rx_data == csum) ? DONE : ERR;
        DONE,
        ERR:     if (rx_data == HDR_BYTE) state_nxt = CNT_HI;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reset wins over a same-edge low byte, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q     <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 16'd0;
      cnt_hi    <= 8'd0;
      cnt       <= 16'd0;
      idx       <= '0;
      hi_byte   <= 8'd0;
      csum      <= 8'd0;
    end else begin
      rdy_q   <= 1'b1;
      imem_we <= 1'b0;
      if (acc) begin
        case (state)
          CNT_HI: cnt_hi <= rx_data;
          CNT_LO: begin
            cnt  <= cnt_new;
            idx  <= '0;
            csum <= 8'd0;
          end
          W_HI: begin
            hi_byte <= rx_data;
            csum    <= csum ^ rx_data;
          end
          W_LO: begin
            imem_we   <= 1'b1;
            imem_addr <= idx[ADDR_W-1:0];
            imem_wd   <= {hi_byte, rx_data};
            csum      <= csum ^ rx_data;
            idx       <= idx + {{ADDR_W{1'b0}}, 1'b1};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader at ADDR_W=10 and ADDR_W=4, checked against frame-derived expectations.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sel;

  logic        rdy10, we10, hold10, done10, err10;
  logic [9:0]  addr10;
  logic [15:0] wd10;
  logic        rdy4, we4, hold4, done4, err4;
  logic [3:0]  addr4;
  logic [15:0] wd4;

  logic        rv10, rv4;
  assign rv10 = rx_valid & ~sel;
  assign rv4  = rx_valid & sel;

  prog_loader #(.ADDR_W(10)) dut10 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rv10), .rx_ready(rdy10),
    .imem_we(we10), .imem_addr(addr10), .imem_wd(wd10),
    .cpu_hold(hold10), .done(done10), .err(err10)
  );

  prog_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rv4), .rx_ready(rdy4),
    .imem_we(we4), .imem_addr(addr4), .imem_wd(wd4),
    .cpu_hold(hold4), .done(done4), .err(err4)
  );

  logic        o_rdy, o_we, o_hold, o_done, o_err;
  logic [9:0]  o_addr;
  logic [15:0] o_wd;
  assign o_rdy  = sel ? rdy4  : rdy10;
  assign o_we   = sel ? we4   : we10;
  assign o_hold = sel ? hold4 : hold10;
  assign o_done = sel ? done4 : done10;
  assign o_err  = sel ? err4  : err10;
  assign o_addr = sel ? {6'd0, addr4} : addr10;
  assign o_wd   = sel ? wd4   : wd10;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr10[$];
  logic [31:0] wr4[$];
  logic [15:0] wq[$];
  logic        prev_we10 = 1'b0;
  logic        prev_we4  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every write; a strobe must never last two consecutive cycles.
  always @(negedge clk) begin
    if (we10) begin
      wr10.push_back({6'd0, addr10, wd10});
      check_val("we10_pulse", {31'd0, prev_we10}, 32'd0);
    end
    if (we4) begin
      wr4.push_back({12'd0, addr4, wd4});
      check_val("we4_pulse", {31'd0, prev_we4}, 32'd0);
    end
    prev_we10 = we10;
    prev_we4  = we4;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    t = 0;
    while (!o_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) check_val("rdy_timeout", {31'd0, o_rdy}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
  endtask

  // Expected writes are the frame's words at addresses 0..N-1; status follows count legality and checksum.
  task automatic run_frame(input bit use4, input logic [15:0] cnt, input logic [7:0] cs_mask,
                           input int junk, input int maxgap);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] q[$];
    bit          cnt_ok;
    bit          exp_ok;
    int          lim;
    int          nexp;
    lim    = use4 ? 16 : 1024;
    cnt_ok = (cnt != 16'd0) && (int'(cnt) <= lim);
    sel    = use4;
    wr10.delete();
    wr4.delete();
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, $urandom_range(0, maxgap));
    end
    send_byte(8'hA5, $urandom_range(0, maxgap));
    @(negedge clk);
    check_val("hdr_hold", {31'd0, o_hold}, 32'd1);
    check_val("hdr_done", {31'd0, o_done}, 32'd0);
    check_val("hdr_err",  {31'd0, o_err},  32'd0);
    send_byte(cnt[15:8], $urandom_range(0, maxgap));
    send_byte(cnt[7:0],  $urandom_range(0, maxgap));
    if (cnt_ok) begin
      cs = 8'd0;
      for (int i = 0; i < int'(cnt); i++) begin
        send_byte(wq[i][15:8], $urandom_range(0, maxgap));
        send_byte(wq[i][7:0],  $urandom_range(0, maxgap));
        cs = cs ^ wq[i][15:8] ^ wq[i][7:0];
        if (i == 0) begin
          @(negedge clk);
          check_val("lat_we",   {31'd0, o_we},   32'd1);
          check_val("lat_addr", {22'd0, o_addr}, 32'd0);
          check_val("lat_wd",   {16'd0, o_wd},   {16'd0, wq[0]});
        end
      end
      send_byte(cs ^ cs_mask, $urandom_range(0, maxgap));
    end
    @(negedge clk);
    exp_ok = cnt_ok && (cs_mask == 8'd0);
    check_val("st_done", {31'd0, o_done}, {31'd0, exp_ok});
    check_val("st_hold", {31'd0, o_hold}, {31'd0, !exp_ok});
    check_val("st_err",  {31'd0, o_err},  {31'd0, !exp_ok});
    repeat (2) @(negedge clk);
    q    = use4 ? wr4 : wr10;
    nexp = cnt_ok ? int'(cnt) : 0;
    check_val("n_writes", q.size(), nexp);
    for (int i = 0; i < nexp && i < q.size(); i++)
      check_val("write", q[i], {i[15:0], wq[i]});
    if (cnt_ok) check_val("addr_held", {22'd0, o_addr}, 32'(int'(cnt) - 1));
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rdy",  {31'd0, o_rdy},  32'd0);
    check_val("rst_we",   {31'd0, o_we},   32'd0);
    check_val("rst_addr", {22'd0, o_addr}, 32'd0);
    check_val("rst_wd",   {16'd0, o_wd},   32'd0);
    check_val("rst_hold", {31'd0, o_hold}, 32'd1);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    check_val("rst_err",  {31'd0, o_err},  32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rdy_up", {31'd0, o_rdy}, 32'd1);

    // Reference frame A5 00 02 A1 23 4C 05 CB, then the CA-corrupted variant, then recovery.
    wq = '{16'hA123, 16'h4C05};
    run_frame(1'b0, 16'd2, 8'h00, 0, 0);
    run_frame(1'b0, 16'd2, 8'h01, 0, 0);
    run_frame(1'b0, 16'd2, 8'h00, 3, 5);

    run_frame(1'b0, 16'h0000, 8'h00, 0, 2);
    run_frame(1'b0, 16'h0401, 8'h00, 0, 0);
    fill_rand(1024);
    run_frame(1'b0, 16'h0400, 8'h00, 0, 0);

    run_frame(1'b1, 16'h0011, 8'h00, 0, 1);
    fill_rand(16);
    run_frame(1'b1, 16'h0010, 8'h00, 2, 2);

    // Reset mid-word: nothing written, loader back to idle.
    sel = 1'b0;
    wr10.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'hA1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_hold", {31'd0, o_hold}, 32'd1);
    check_val("mid_rdy",  {31'd0, o_rdy},  32'd0);
    check_val("mid_done", {31'd0, o_done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rdy_up", {31'd0, o_rdy}, 32'd1);
    check_val("mid_nowr", wr10.size(), 32'd0);

    // Reset on the same edge as the low byte cancels that write.
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hA1, 0);
    @(negedge clk);
    rx_data  = 8'h23;
    rx_valid = 1'b1;
    reset    = 1'b0;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    check_val("cancel_we", {31'd0, o_we}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("cancel_nowr", wr10.size(), 32'd0);
    wq = '{16'hA123, 16'h4C05};
    run_frame(1'b0, 16'd2, 8'h00, 0, 0);

    for (int k = 0; k < 24; k++) begin
      bit          u4;
      int          n;
      logic [7:0]  m;
      u4 = 1'($urandom_range(0, 1));
      n  = u4 ? $urandom_range(1, 16) : $urandom_range(1, 8);
      m  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_rand(n);
      run_frame(u4, 16'(n), m, $urandom_range(0, 3), 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
